aes_equiv_sequencer: RTL and testbench

Self-checking stimulus/compare sequencer for the AES locking flow. It sits directly upstream of a pair of AES cores: the unlocked original and the latch-locked variant. It drives their shared `ld`/`key`/`text_in` inputs from LFSRs and consumes their `done`/`text_out` results. It reports whether the locked core, with its key applied externally, is output-equivalent to the original over a run of pseudo-random vectors. It is synthesizable, so equivalence runs can execute on FPGA/emulation as well as in simulation.

---
 rtl/aes_equiv_sequencer_if.sv | 28 ++
 rtl/aes_equiv_sequencer.sv | 120 ++++++++++++
 tb/tb_aes_equiv_sequencer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_equiv_sequencer_if.sv
// Handshake/data bundle between the equivalence sequencer and the AES core pair.
// master: the sequencer side; slave: the cores plus whoever issues start.
interface aes_equiv_sequencer_if;
  logic         start;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic         done_orig;
  logic [127:0] text_out_orig;
  logic         done_lbll;
  logic [127:0] text_out_lbll;
  logic         busy;
  logic         finished;
  logic         pass;
  logic [15:0]  err_count;
  logic [15:0]  vec_count;
  logic [15:0]  first_fail;

  modport master (
    input  start, done_orig, text_out_orig, done_lbll, text_out_lbll,
    output ld, key, text_in, busy, finished, pass, err_count, vec_count, first_fail
  );

  modport slave (
    output start, done_orig, text_out_orig, done_lbll, text_out_lbll,
    input  ld, key, text_in, busy, finished, pass, err_count, vec_count, first_fail
  );
endinterface

// File: rtl/aes_equiv_sequencer.sv
// Drives LFSR key/plaintext vectors into an original and a locked AES core and
// counts vectors where their {done, text_out} results disagree.
module aes_equiv_sequencer #(
  parameter int unsigned  NVEC        = 30,
  parameter int unsigned  WAIT_CYCLES = 50,
  parameter logic [127:0] KEY_SEED    = 128'h1,
  parameter logic [127:0] TXT_SEED    = 128'h2
) (
  input logic                   clk,
  input logic                   rst,
  aes_equiv_sequencer_if.master bus
);

  typedef enum logic [2:0] {StIdle, StLoad, StWait, StCheck, StDone} state_e;

  localparam logic [15:0] NoFail = 16'hFFFF;

  state_e       state_q, state_d;
  logic [31:0]  wait_q, wait_d;
  logic [127:0] key_q, key_d;
  logic [127:0] txt_q, txt_d;
  logic [15:0]  err_q, err_d;
  logic [15:0]  vec_q, vec_d;
  logic [15:0]  ff_q, ff_d;

  logic         mismatch;
  logic [15:0]  vec_inc;

  // Galois shift-left step, x^128 + x^7 + x^2 + x + 1 (feedback taps 0x87).
  function automatic logic [127:0] lfsr_step(input logic [127:0] s);
    return {s[126:0], 1'b0} ^ (s[127] ? 128'h87 : 128'h0);
  endfunction

  assign mismatch = {bus.done_orig, bus.text_out_orig} != {bus.done_lbll, bus.text_out_lbll};
  assign vec_inc  = vec_q + 16'd1;

  // Next-state logic; the LFSRs advance only on edges that enter LOAD.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    key_d   = key_q;
    txt_d   = txt_q;
    err_d   = err_q;
    vec_d   = vec_q;
    ff_d    = ff_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StLoad;
          err_d   = 16'd0;
          vec_d   = 16'd0;
          ff_d    = NoFail;
          key_d   = lfsr_step(key_q);
          txt_d   = lfsr_step(txt_q);
        end
      end
      StLoad: begin
        state_d = StWait;
        wait_d  = WAIT_CYCLES - 32'd1;
      end
      StWait: begin
        if (wait_q == 32'd0) begin
          state_d = StCheck;
        end else begin
          wait_d = wait_q - 32'd1;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
          if (ff_q == NoFail) ff_d = vec_q;
        end
        vec_d = vec_inc;
        if ({16'd0, vec_inc} == NVEC) begin
          state_d = StDone;
        end else begin
          state_d = StLoad;
          key_d   = lfsr_step(key_q);
          txt_d   = lfsr_step(txt_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and result registers; reset abandons any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= 32'd0;
      key_q   <= KEY_SEED;
      txt_q   <= TXT_SEED;
      err_q   <= 16'd0;
      vec_q   <= 16'd0;
      ff_q    <= NoFail;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      key_q   <= key_d;
      txt_q   <= txt_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      ff_q    <= ff_d;
    end
  end

  // Outputs are straight decodes of registered state, so they change only at edges.
  always_comb begin
    bus.ld         = (state_q == StLoad);
    bus.busy       = (state_q == StLoad) || (state_q == StWait) || (state_q == StCheck);
    bus.finished   = (state_q == StDone);
    bus.pass       = (state_q == StDone) && (err_q == 16'd0);
    bus.key        = key_q;
    bus.text_in    = txt_q;
    bus.err_count  = err_q;
    bus.vec_count  = vec_q;
    bus.first_fail = ff_q;
  end

endmodule

// File: tb/tb_aes_equiv_sequencer.sv
// Directed bench for aes_equiv_sequencer with a pair of toy AES core models.
module tb_aes_equiv_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_equiv_sequencer_if bus ();

  aes_equiv_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] kexp, texp;
  logic [127:0] res;
  logic         done_r;
  int           dcnt;
  logic         flip_now    = 1'b0;
  logic         force_done0 = 1'b0;
  logic [31:0]  flip_mask   = 32'h0;

  // Toy core: result is a fixed mix of key and text, done 10 cycles after ld.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      res    <= '0;
      done_r <= 1'b0;
      dcnt   <= 0;
    end else if (bus.ld) begin
      res    <= bus.key ^ {bus.text_in[63:0], bus.text_in[127:64]};
      done_r <= 1'b0;
      dcnt   <= 10;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) done_r <= 1'b1;
    end
  end

  assign bus.done_orig     = done_r;
  assign bus.text_out_orig = res;
  assign bus.done_lbll     = force_done0 ? 1'b0 : done_r;
  assign bus.text_out_lbll = res ^ {127'd0, flip_now};

  function automatic logic [127:0] step(input logic [127:0] s);
    logic [127:0] n;
    n = s << 1;
    if (s[127]) n = n ^ 128'h87;
    return n;
  endfunction

  // Pulses start, then follows the run to DONE, tracking ld pulses and vector values.
  task automatic do_run(input bit poke_start, output int n_ld, output int bad_sp,
                        output int bad_key, output int cycles, output logic [127:0] first_key);
    int cyc;
    int last;
    int first;
    n_ld = 0; bad_sp = 0; bad_key = 0; cycles = -1; last = 0; first = 0; first_key = '0;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cyc = 0;
    while (bus.finished !== 1'b1 && cyc < 4000) begin
      if (bus.ld === 1'b1) begin
        kexp = step(kexp);
        texp = step(texp);
        if (bus.key !== kexp || bus.text_in !== texp) bad_key++;
        if (n_ld == 0) begin
          first     = cyc;
          first_key = bus.key;
        end else if (cyc - last != 52) begin
          bad_sp++;
        end
        last     = cyc;
        flip_now = flip_mask[n_ld[4:0]];
        n_ld++;
      end
      bus.start = poke_start && (n_ld == 3) && (cyc - last == 20);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    flip_now  = 1'b0;
    if (bus.finished === 1'b1) cycles = cyc - first;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    #12;
    n_checks++; if (bus.ld !== 1'b0) begin n_fail++; $display("FAIL reset_ld got %0h exp 0", bus.ld); end
    n_checks++; if (bus.key !== 128'h1) begin n_fail++; $display("FAIL reset_key got %0h exp 1", bus.key); end
    n_checks++; if (bus.text_in !== 128'h2) begin n_fail++; $display("FAIL reset_text got %0h exp 2", bus.text_in); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0h exp 0", bus.busy); end
    n_checks++; if (bus.finished !== 1'b0) begin n_fail++; $display("FAIL reset_finished got %0h exp 0", bus.finished); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0h exp 0", bus.pass); end
    n_checks++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL reset_err got %0h exp 0", bus.err_count); end
    n_checks++; if (bus.vec_count !== 16'd0) begin n_fail++; $display("FAIL reset_vec got %0h exp 0", bus.vec_count); end
    n_checks++; if (bus.first_fail !== 16'hFFFF) begin n_fail++; $display("FAIL reset_ff got %0h exp ffff", bus.first_fail); end
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.ld !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold got ld=%0h busy=%0h exp 0 0", bus.ld, bus.busy); end
    kexp = 128'h1;
    texp = 128'h2;
  endtask

  task automatic test_clean_run();
    int n_ld, bad_sp, bad_key, cycles;
    logic [127:0] fk;
    do_run(1'b0, n_ld, bad_sp, bad_key, cycles, fk);
    n_checks++; if (n_ld !== 30) begin n_fail++; $display("FAIL clean_ld_count got %0d exp 30", n_ld); end
    n_checks++; if (bad_sp !== 0) begin n_fail++; $display("FAIL clean_spacing got %0d bad exp 0", bad_sp); end
    n_checks++; if (bad_key !== 0) begin n_fail++; $display("FAIL clean_vectors got %0d bad exp 0", bad_key); end
    n_checks++; if (fk !== 128'h2) begin n_fail++; $display("FAIL clean_first_key got %0h exp 2", fk); end
    n_checks++; if (cycles !== 1560) begin n_fail++; $display("FAIL clean_cycles got %0d exp 1560", cycles); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL clean_pass got %0h exp 1", bus.pass); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy got %0h exp 0", bus.busy); end
    n_checks++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL clean_err got %0h exp 0", bus.err_count); end
    n_checks++; if (bus.vec_count !== 16'd30) begin n_fail++; $display("FAIL clean_vec got %0d exp 30", bus.vec_count); end
    n_checks++; if (bus.first_fail !== 16'hFFFF) begin n_fail++; $display("FAIL clean_ff got %0h exp ffff", bus.first_fail); end
    repeat (5) @(negedge clk);
    n_checks++; if (bus.finished !== 1'b1 || bus.vec_count !== 16'd30) begin
      n_fail++; $display("FAIL done_hold got fin=%0h vec=%0d exp 1 30", bus.finished, bus.vec_count); end
  endtask

  task automatic test_flip_bit0();
    int n_ld, bad_sp, bad_key, cycles;
    logic [127:0] fk;
    flip_mask = 32'h0000_0090;
    do_run(1'b0, n_ld, bad_sp, bad_key, cycles, fk);
    flip_mask = 32'h0;
    n_checks++; if (bus.err_count !== 16'd2) begin n_fail++; $display("FAIL flip_err got %0d exp 2", bus.err_count); end
    n_checks++; if (bus.first_fail !== 16'd4) begin n_fail++; $display("FAIL flip_ff got %0d exp 4", bus.first_fail); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL flip_pass got %0h exp 0", bus.pass); end
    n_checks++; if (bus.finished !== 1'b1) begin n_fail++; $display("FAIL flip_finished got %0h exp 1", bus.finished); end
    n_checks++; if (bad_key !== 0) begin n_fail++; $display("FAIL flip_vectors got %0d bad exp 0", bad_key); end
  endtask

  task automatic test_done_low();
    int n_ld, bad_sp, bad_key, cycles;
    logic [127:0] fk;
    force_done0 = 1'b1;
    do_run(1'b0, n_ld, bad_sp, bad_key, cycles, fk);
    force_done0 = 1'b0;
    n_checks++; if (bus.err_count !== 16'd30) begin n_fail++; $display("FAIL done0_err got %0d exp 30", bus.err_count); end
    n_checks++; if (bus.first_fail !== 16'd0) begin n_fail++; $display("FAIL done0_ff got %0d exp 0", bus.first_fail); end
    n_checks++; if (bus.pass !== 1'b0) begin n_fail++; $display("FAIL done0_pass got %0h exp 0", bus.pass); end
    n_checks++; if (bus.vec_count !== 16'd30) begin n_fail++; $display("FAIL done0_vec got %0d exp 30", bus.vec_count); end
  endtask

  task automatic test_back_to_back();
    int n_ld, bad_sp, bad_key, cycles;
    logic [127:0] fk, prev;
    prev = kexp;
    do_run(1'b1, n_ld, bad_sp, bad_key, cycles, fk);
    n_checks++; if (fk !== step(prev)) begin n_fail++; $display("FAIL b2b_first_key got %0h exp %0h", fk, step(prev)); end
    n_checks++; if (n_ld !== 30) begin n_fail++; $display("FAIL b2b_ld_count got %0d exp 30", n_ld); end
    n_checks++; if (bad_sp !== 0) begin n_fail++; $display("FAIL b2b_spacing got %0d bad exp 0", bad_sp); end
    n_checks++; if (bad_key !== 0) begin n_fail++; $display("FAIL b2b_vectors got %0d bad exp 0", bad_key); end
    n_checks++; if (bus.err_count !== 16'd0) begin n_fail++; $display("FAIL b2b_err got %0d exp 0", bus.err_count); end
    n_checks++; if (bus.first_fail !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_ff got %0h exp ffff", bus.first_fail); end
    n_checks++; if (bus.pass !== 1'b1) begin n_fail++; $display("FAIL b2b_pass got %0h exp 1", bus.pass); end
  endtask

  task automatic test_reset_midrun();
    int n_ld, bad_sp, bad_key, cycles, cnt, cyc;
    logic [127:0] fk;
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    cnt = 0; cyc = 0;
    while (cnt < 11 && cyc < 2000) begin
      if (bus.ld === 1'b1) cnt++;
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cnt !== 11) begin n_fail++; $display("FAIL mid_reach_vec10 got %0d loads exp 11", cnt); end
    repeat (10) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1 || bus.vec_count !== 16'd10) begin
      n_fail++; $display("FAIL mid_running got busy=%0h vec=%0d exp 1 10", bus.busy, bus.vec_count); end
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.ld !== 1'b0 || bus.finished !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_ctrl got busy=%0h ld=%0h fin=%0h exp 0 0 0", bus.busy, bus.ld, bus.finished); end
    n_checks++; if (bus.key !== 128'h1 || bus.text_in !== 128'h2) begin
      n_fail++; $display("FAIL mid_rst_lfsr got key=%0h text=%0h exp 1 2", bus.key, bus.text_in); end
    n_checks++; if (bus.vec_count !== 16'd0 || bus.err_count !== 16'd0 || bus.first_fail !== 16'hFFFF) begin
      n_fail++; $display("FAIL mid_rst_cnt got vec=%0h err=%0h ff=%0h exp 0 0 ffff",
                         bus.vec_count, bus.err_count, bus.first_fail); end
    @(negedge clk); rst = 1'b0;
    kexp = 128'h1;
    texp = 128'h2;
    do_run(1'b0, n_ld, bad_sp, bad_key, cycles, fk);
    n_checks++; if (fk !== 128'h2) begin n_fail++; $display("FAIL mid_first_key got %0h exp 2", fk); end
    n_checks++; if (n_ld !== 30 || bad_key !== 0) begin
      n_fail++; $display("FAIL mid_rerun got loads=%0d badvec=%0d exp 30 0", n_ld, bad_key); end
    n_checks++; if (bus.pass !== 1'b1 || bus.vec_count !== 16'd30) begin
      n_fail++; $display("FAIL mid_rerun_result got pass=%0h vec=%0d exp 1 30", bus.pass, bus.vec_count); end
  endtask

  initial begin
    test_reset();
    test_clean_run();
    test_flip_bit0();
    test_done_low();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
